ntt_addr_gen: RTL
=================

Name: ntt_addr_gen

Overview:
- Control and address-generation stage directly upstream of the butterfly unit.
- Runs one full in-place NTT over an N-coefficient polynomial: CT forward (ct=1) or GS inverse (ct=0).
- Issues one butterfly per cycle: coefficient-pair read addresses plus twiddle address.
- Returns matching write-back addresses, delayed to line up with the butterfly's r0/r1 outputs.
- Drives the butterfly's CT and i inputs, held constant for the whole run.

Parameters:
LOGN, 8, log2 of polynomial length N (N = 2^LOGN); butterflies per stage = N/2
MEM_LAT, 1, coefficient/twiddle memory read latency in cycles
LAT_BASE, 5, butterfly input-to-r0/r1 latency when i=0; each unit of i adds one cycle

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
ct  in  1  mode, latched at start: 1 = CT forward, 0 = GS inverse
lat_sel  in  2  butterfly reduction select, latched at start; drives butterfly i
rd_en  out  1  read strobe for coefficient and twiddle memories
rd_addr_a  out  LOGN  address of upper coefficient
rd_addr_b  out  LOGN  address of lower coefficient
tw_addr  out  LOGN  twiddle ROM address
wr_en  out  1  write strobe, aligned with butterfly r0/r1
wr_addr_a  out  LOGN  write address for r0
wr_addr_b  out  LOGN  write address for r1
bf_ct  out  1  latched ct, to butterfly CT
bf_i  out  2  latched lat_sel, to butterfly i
stage  out  LOGN-width counter  current stage index 0..LOGN-1
busy  out  1  high from first ISSUE cycle through last DRAIN cycle
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (async, active low):
  - All outputs, counters and the delay line clear to 0; FSM goes to IDLE.
  - Reset mid-run discards in-flight writes; wr_en is low immediately.
- FSM has four states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE: on start=1, latch ct and lat_sel, clear stage and k, go to ISSUE.
  - start=1 in any other state is ignored.
  - ISSUE: N/2 cycles, k = 0..N/2-1, rd_en=1. After k=N/2-1, go to DRAIN.
  - DRAIN: D cycles with rd_en=0.
    - If stage < LOGN-1: increment stage, clear k, return to ISSUE.
    - Otherwise go to FIN.
  - FIN: done=1 and busy=0 for one cycle, then IDLE.
- Write delay: D = MEM_LAT + LAT_BASE + lat_sel (latched).
- Per-stage addressing:
  - len = N >> (stage+1) in CT mode; len = 1 << stage in GS mode.
  - g = k / len; j = k mod len. len is a power of two, so use shift/mask only, no divider.
  - rd_addr_a = 2*g*len + j; rd_addr_b = rd_addr_a + len.
  - CT: tw_addr = (1 << stage) + g.
  - GS: tw_addr = (N >> (stage+1)) + g.
  - All address values fit in LOGN bits with no wrap.
- Write-back alignment: wr_en, wr_addr_a, wr_addr_b equal rd_en, rd_addr_a, rd_addr_b delayed by exactly D cycles.
  - Implemented as a shift line of depth MEM_LAT+LAT_BASE+3, with the tap selected by the latched lat_sel.
- Hazard rule: DRAIN length D guarantees the last write of stage s (cycle L+D) precedes the first read of stage s+1 (cycle L+D+1). No overlap between stages.
- Timing and outputs:
  - Outputs are registered.
  - First rd_en is the cycle after start is sampled.
  - Total busy cycles = LOGN*(N/2 + D).
- bf_ct and bf_i are constant from latch until the next start.

Decomposition:
- Shared package ntt_pkg holds:
  - FSM state enum (IDLE/ISSUE/DRAIN/FIN)
  - defaults for LOGN, MEM_LAT and LAT_BASE
  - function for max delay depth
- One sub-module: ntt_delay_line, a parameterized-width shift register with a runtime tap select. It carries {en, addr_a, addr_b}.

Test Plan:
- CT run, LOGN=3, lat_sel=0:
  - stage0: pairs (0,4)(1,5)(2,6)(3,7), all with tw=1.
  - stage1: (0,2)(1,3) with tw=2; (4,6)(5,7) with tw=3.
  - stage2: (0,1)tw4, (2,3)tw5, (4,5)tw6, (6,7)tw7.
  - wr_* equals rd_* shifted by D=6.
- GS run, LOGN=3:
  - stage0: (0,1)tw4, (2,3)tw5, (4,5)tw6, (6,7)tw7.
  - stage1: (0,2)(1,3) with tw=2; (4,6)(5,7) with tw=3.
  - stage2: (0,4)..(3,7), all with tw=1.
- Latency sweep with LOGN=8:
  - lat_sel=0..3 gives wr_en-to-rd_en lag of 6, 7, 8, 9 cycles.
  - busy lasts 8*(128+D) cycles: 1072 / 1080 / 1088 / 1096.
  - done is a single pulse.
- Stage hazard:
  - The last wr_en of each stage occurs exactly one cycle before the first rd_en of the next stage.
  - No rd_en occurs while any write of the prior stage is pending.
- start during busy and mode change: pulse start with ct flipped mid-run -> ignored; bf_ct and bf_i unchanged; the run completes normally.
- Reset mid-run: assert reset low during stage 2 -> wr_en, rd_en and busy drop to 0 asynchronously. After release, a new start runs a clean full sequence from stage 0.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types and defaults for the NTT address-generation stage.
package ntt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } ntt_state_e;

  localparam int LOGN_DEF     = 8;
  localparam int MEM_LAT_DEF  = 1;
  localparam int LAT_BASE_DEF = 5;

  // Deepest write-back delay: the largest butterfly latency select adds 3 cycles.
  function automatic int max_delay(input int mem_lat, input int lat_base);
    return mem_lat + lat_base + 3;
  endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Shift register of fixed depth with a runtime-selected output tap.
module ntt_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 9,
  parameter int TAP_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     din,
  input  logic [TAP_W-1:0] tap,
  output logic [W-1:0]     dout
);

  logic [DEPTH-1:0][W-1:0] sr_q;
  logic [DEPTH-1:0][W-1:0] sr_d;

  always_comb begin
    sr_d = {sr_q[DEPTH-2:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Tap t presents din delayed by t+1 cycles.
  assign dout = sr_q[tap];

endmodule

// File: rtl/ntt_addr_gen.sv
// Sequencer for one in-place NTT: issues butterfly read/twiddle addresses and
// returns write-back addresses delayed to meet the butterfly outputs.
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int LOGN     = LOGN_DEF,
  parameter int MEM_LAT  = MEM_LAT_DEF,
  parameter int LAT_BASE = LAT_BASE_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            ct,
  input  logic [1:0]      lat_sel,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-1:0] tw_addr,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b,
  output logic            bf_ct,
  output logic [1:0]      bf_i,
  output logic [LOGN-1:0] stage,
  output logic            busy,
  output logic            done
);

  localparam int DEPTH = max_delay(MEM_LAT, LAT_BASE);
  localparam int TAP_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DLW   = 2 * LOGN + 1;
  localparam logic [LOGN-1:0] K_LAST = LOGN'((1 << (LOGN - 1)) - 1);
  localparam logic [LOGN-1:0] S_LAST = LOGN'(LOGN - 1);

  ntt_state_e      state_q, state_d;
  logic [LOGN-1:0] k_q, k_d;
  logic [LOGN-1:0] stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            ct_q, ct_d;
  logic [1:0]      lat_q, lat_d;
  logic            rd_en_q, rd_en_d;
  logic [LOGN-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d, tw_q, tw_d;
  logic            busy_q, busy_d, done_q, done_d;

  logic [CNT_W-1:0] drain_last;
  logic [LOGN-1:0]  lsh, len, grp, ofs;
  logic [TAP_W-1:0] tap;
  logic [DLW-1:0]   dl_out;

  assign drain_last = CNT_W'(MEM_LAT + LAT_BASE - 1) + CNT_W'(lat_q);
  assign tap        = TAP_W'(MEM_LAT + LAT_BASE - 1) + TAP_W'(lat_q);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    ct_d    = ct_q;
    lat_d   = lat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          ct_d    = ct;
          lat_d   = lat_sel;
          stage_d = '0;
          k_d     = '0;
        end
      end
      ST_ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Drain lasts exactly the write delay so stages never overlap.
        if (cnt_q == drain_last) begin
          if (stage_q == S_LAST) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_ISSUE;
            stage_d = stage_q + 1'b1;
            k_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Addresses come from next-state values so they register alongside rd_en.
  always_comb begin
    lsh     = ct_d ? (S_LAST - stage_d) : stage_d;
    len     = LOGN'(1) << lsh;
    grp     = k_d >> lsh;
    ofs     = k_d & (len - 1'b1);
    rd_a_d  = (grp << (lsh + 1'b1)) | ofs;
    rd_b_d  = rd_a_d | len;
    tw_d    = (ct_d ? (LOGN'(1) << stage_d) : (LOGN'(1) << (S_LAST - stage_d))) + grp;
    rd_en_d = (state_d == ST_ISSUE);
    busy_d  = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d  = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      ct_q    <= 1'b0;
      lat_q   <= '0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      ct_q    <= ct_d;
      lat_q   <= lat_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      tw_q    <= tw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  ntt_delay_line #(
    .W     (DLW),
    .DEPTH (DEPTH),
    .TAP_W (TAP_W)
  ) u_delay (
    .clk   (clk),
    .rst_n (reset),
    .din   ({rd_en_q, rd_a_q, rd_b_q}),
    .tap   (tap),
    .dout  (dl_out)
  );

  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign tw_addr   = tw_q;
  assign wr_en     = dl_out[DLW-1];
  assign wr_addr_a = dl_out[2*LOGN-1:LOGN];
  assign wr_addr_b = dl_out[LOGN-1:0];
  assign bf_ct     = ct_q;
  assign bf_i      = lat_q;
  assign stage     = stage_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
